// File: rtl/dp_memory_hs_if.sv
// dp_memory_hs_if
//   Bundles the command (fetch) port and the handshaked data (load/store)
//   port of dp_memory_hs.
//   master modport: CPU side (drives requests, receives data/status).
//   slave modport : memory side.
//   Command port : oe_c, com_addr -> com_data, com_valid
//   Data port    : d_req, we, be, data_addr, data_write ->
//                  data_read, d_ack, d_busy, d_err
interface dp_memory_hs_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  localparam int BE_W = DATA_W / 8;

  logic              oe_c;
  logic [ADDR_W-1:0] com_addr;
  logic [DATA_W-1:0] com_data;
  logic              com_valid;

  logic              d_req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;
  logic              d_ack;
  logic              d_busy;
  logic              d_err;

  modport master (
    output oe_c, com_addr, d_req, we, be, data_addr, data_write,
    input  com_data, com_valid, data_read, d_ack, d_busy, d_err
  );

  modport slave (
    input  oe_c, com_addr, d_req, we, be, data_addr, data_write,
    output com_data, com_valid, data_read, d_ack, d_busy, d_err
  );
endinterface

// File: rtl/dp_memory_hs.sv
// dp_memory_hs
//   Dual-port synchronous RAM shared by the CPU fetch and load/store units.
//   Command port: read-only, one word per edge while oe_c is high.
//   Data port   : request/acknowledge handshake with WAIT_CYCLES extra
//                 latency, byte-lane writes and out-of-range error reporting.
//   A write committing on the same edge as a fetch of the same address is
//   forwarded to the fetch (write-first).
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-high reset (RAM contents are kept)
//   bus  - dp_memory_hs_if slave modport (command + data ports)
module dp_memory_hs #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  dp_memory_hs_if.slave    bus
);

  localparam int               BE_W     = DATA_W / 8;
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]       CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;

  logic              lat_we;
  logic [BE_W-1:0]   lat_be;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] com_data_q;
  logic              com_valid_q;
  logic [DATA_W-1:0] data_read_q;
  logic              d_err_q;

  logic              accept;
  logic              do_access;
  logic              acc_we;
  logic [BE_W-1:0]   acc_be;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_in_range;
  logic [IDX_W-1:0]  acc_idx;
  logic              commit_wr;
  logic [DATA_W-1:0] wr_word;

  logic              com_in_range;
  logic [IDX_W-1:0]  com_idx;
  logic              com_hit;

  assign accept = bus.d_req && (state != S_WAIT);

  // With no wait states the access happens on the accepting edge, so it
  // must use the live request inputs; otherwise it uses the latched copy.
  always_comb begin
    do_access = 1'b0;
    acc_we    = 1'b0;
    acc_be    = '0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (WAIT_CYCLES == 0) begin
      do_access = accept;
      acc_we    = bus.we;
      acc_be    = bus.be;
      acc_addr  = bus.data_addr;
      acc_wdata = bus.data_write;
    end else begin
      do_access = (state == S_WAIT) && (wait_cnt == 4'd0);
      acc_we    = lat_we;
      acc_be    = lat_be;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  assign acc_in_range = {1'b0, acc_addr} < DEPTH_L;
  assign acc_idx      = acc_addr[IDX_W-1:0];
  assign commit_wr    = do_access && acc_we && acc_in_range;

  // Word as it will look after the committing write; used to forward
  // into a same-edge fetch of the same address.
  always_comb begin
    wr_word = mem[acc_idx];
    for (int i = 0; i < BE_W; i++) begin
      if (acc_be[i]) begin
        wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
      end
    end
  end

  // RAM array has no reset; a write still pending when rst rises is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign com_in_range = {1'b0, bus.com_addr} < DEPTH_L;
  assign com_idx      = bus.com_addr[IDX_W-1:0];
  assign com_hit      = commit_wr && (bus.com_addr == acc_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      com_data_q  <= '0;
      com_valid_q <= 1'b0;
    end else if (bus.oe_c) begin
      com_valid_q <= 1'b1;
      if (!com_in_range) begin
        com_data_q <= '0;
      end else if (com_hit) begin
        com_data_q <= wr_word;
      end else begin
        com_data_q <= mem[com_idx];
      end
    end else begin
      com_valid_q <= 1'b0;
    end
  end

  // Data-port FSM. d_err is registered on the access edge so that it lines
  // up with the ACK state that always follows an access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      lat_we      <= 1'b0;
      lat_be      <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      data_read_q <= '0;
      d_err_q     <= 1'b0;
    end else begin
      d_err_q <= do_access && !acc_in_range;
      if (do_access && !acc_we) begin
        data_read_q <= acc_in_range ? mem[acc_idx] : '0;
      end
      case (state)
        S_IDLE, S_ACK: begin
          if (bus.d_req) begin
            lat_we    <= bus.we;
            lat_be    <= bus.be;
            lat_addr  <= bus.data_addr;
            lat_wdata <= bus.data_write;
            if (WAIT_CYCLES == 0) begin
              state <= S_ACK;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= CNT_INIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.com_data  = com_data_q;
  assign bus.com_valid = com_valid_q;
  assign bus.data_read = data_read_q;
  assign bus.d_ack     = (state == S_ACK);
  assign bus.d_busy    = (state == S_WAIT);
  assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_dp_memory_hs.sv
// tb_dp_memory_hs
//   Bench for dp_memory_hs with two instances:
//     dut_a : DATA_W=16, DEPTH=512, WAIT_CYCLES=0 (table-driven traffic,
//             byte lanes, out-of-range, fetch port, collision, async reset)
//     dut_b : DATA_W=8, DEPTH=1024, WAIT_CYCLES=3 (latency, busy, ignored
//             and back-to-back requests, reset dropping a pending write)
//   Expected data-port results are queued when a request is driven and
//   compared when d_ack is seen.
module tb_dp_memory_hs;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  dp_memory_hs_if #(.DATA_W(16), .ADDR_W(10)) ifa ();
  dp_memory_hs_if #(.DATA_W(8),  .ADDR_W(10)) ifb ();

  dp_memory_hs #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .WAIT_CYCLES(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  dp_memory_hs #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs [13];
  exp_t sb_a [$];
  exp_t sb_b [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    ifa.we         = v.we;
    ifa.be         = v.be;
    ifa.data_addr  = v.addr;
    ifa.data_write = v.wdata;
    ifa.d_req      = 1'b1;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_a.push_back(e);
  endtask

  task automatic pushB(input logic [7:0] rdata);
    exp_t e;
    e.rdata = {8'h00, rdata};
    e.err   = 1'b0;
    sb_b.push_back(e);
  endtask

  task automatic waitAckB(input int max_cycles);
    int n;
    n = 0;
    while (ifb.d_ack !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput("ackB_wait", 32'(ifb.d_ack), 32'd1);
  endtask

  task automatic checkResetA();
    checkOutput("rstA_com_data",  32'(ifa.com_data),  32'd0);
    checkOutput("rstA_com_valid", 32'(ifa.com_valid), 32'd0);
    checkOutput("rstA_data_read", 32'(ifa.data_read), 32'd0);
    checkOutput("rstA_d_ack",     32'(ifa.d_ack),     32'd0);
    checkOutput("rstA_d_busy",    32'(ifa.d_busy),    32'd0);
    checkOutput("rstA_d_err",     32'(ifa.d_err),     32'd0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && ifa.d_ack === 1'b1) begin
      if (sb_a.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL ackA_unexpected: got ack with empty queue at %0t", $time);
      end else begin
        e = sb_a.pop_front();
        checkOutput("rdataA", 32'(ifa.data_read), 32'(e.rdata));
        checkOutput("errA",   32'(ifa.d_err),     32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && ifb.d_ack === 1'b1) begin
      if (sb_b.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL ackB_unexpected: got ack with empty queue at %0t", $time);
      end else begin
        e = sb_b.pop_front();
        checkOutput("rdataB", 32'(ifb.data_read), 32'(e.rdata));
        checkOutput("errB",   32'(ifb.d_err),     32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           we    be     addr     wdata     exp_rdata  exp_err
    vecs[0]  = '{1'b1, 2'b11, 10'd0,   16'h0011, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 10'd1,   16'h0033, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 10'd0,   16'h0000, 16'h0011, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 10'd1,   16'h0000, 16'h0033, 1'b0};
    vecs[4]  = '{1'b1, 2'b11, 10'd5,   16'hABCD, 16'h0033, 1'b0};
    vecs[5]  = '{1'b1, 2'b01, 10'd5,   16'h1234, 16'h0033, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 10'd5,   16'h0000, 16'hAB34, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 10'd5,   16'hFFFF, 16'hAB34, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 10'd5,   16'h0000, 16'hAB34, 1'b0};
    vecs[9]  = '{1'b1, 2'b11, 10'd88,  16'h0077, 16'hAB34, 1'b0};
    vecs[10] = '{1'b1, 2'b11, 10'd600, 16'h0055, 16'hAB34, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 10'd600, 16'h0000, 16'h0000, 1'b1};
    vecs[12] = '{1'b0, 2'b00, 10'd88,  16'h0000, 16'h0077, 1'b0};

    rst = 1'b1;
    ifa.oe_c = 1'b0; ifa.com_addr = '0; ifa.d_req = 1'b0; ifa.we = 1'b0;
    ifa.be = '0; ifa.data_addr = '0; ifa.data_write = '0;
    ifb.oe_c = 1'b0; ifb.com_addr = '0; ifb.d_req = 1'b0; ifb.we = 1'b0;
    ifb.be = '0; ifb.data_addr = '0; ifb.data_write = '0;

    step();
    step();
    checkResetA();
    checkOutput("rstB_d_busy",    32'(ifb.d_busy),    32'd0);
    checkOutput("rstB_data_read", 32'(ifb.data_read), 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back table traffic on the zero-wait instance.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput("ackA_latency", 32'(ifa.d_ack),  32'd1);
      checkOutput("busyA",        32'(ifa.d_busy), 32'd0);
    end
    ifa.d_req = 1'b0;
    step();
    checkOutput("ackA_pulse", 32'(ifa.d_ack), 32'd0);

    // Fetch port: in-range, out-of-range, and hold when disabled.
    ifa.oe_c = 1'b1; ifa.com_addr = 10'd5;
    step();
    checkOutput("comA_data5",  32'(ifa.com_data),  32'h0000AB34);
    checkOutput("comA_valid",  32'(ifa.com_valid), 32'd1);
    ifa.com_addr = 10'd600;
    step();
    checkOutput("comA_oor", 32'(ifa.com_data), 32'd0);
    ifa.com_addr = 10'd1;
    step();
    checkOutput("comA_data1", 32'(ifa.com_data), 32'h00000033);
    ifa.oe_c = 1'b0; ifa.com_addr = 10'd0;
    step();
    checkOutput("comA_valid_off", 32'(ifa.com_valid), 32'd0);
    checkOutput("comA_hold",      32'(ifa.com_data),  32'h00000033);

    // Asynchronous reset asserted mid-cycle while outputs are non-zero.
    ifa.oe_c = 1'b1; ifa.com_addr = 10'd1;
    ifa.we = 1'b0; ifa.data_addr = 10'd1; ifa.d_req = 1'b1;
    step();
    checkOutput("preRstA_data_read", 32'(ifa.data_read), 32'h00000033);
    checkOutput("preRstA_d_ack",     32'(ifa.d_ack),     32'd1);
    #2 rst = 1'b1;
    #1 checkResetA();
    ifa.d_req = 1'b0; ifa.oe_c = 1'b0;
    #2 rst = 1'b0;
    step();
    checkOutput("postRstA_d_busy", 32'(ifa.d_busy), 32'd0);
    checkOutput("postRstA_d_ack",  32'(ifa.d_ack),  32'd0);

    // Collision: fetch of the address being written sees the new word.
    ifa.oe_c = 1'b1; ifa.com_addr = 10'd7;
    ifa.we = 1'b1; ifa.be = 2'b11; ifa.data_addr = 10'd7; ifa.data_write = 16'h009E;
    ifa.d_req = 1'b1;
    begin
      exp_t e;
      e.rdata = 16'h0000;
      e.err   = 1'b0;
      sb_a.push_back(e);
    end
    step();
    checkOutput("collA_data",  32'(ifa.com_data),  32'h0000009E);
    checkOutput("collA_valid", 32'(ifa.com_valid), 32'd1);
    ifa.d_req = 1'b0; ifa.oe_c = 1'b0;
    step();
    ifa.oe_c = 1'b1; ifa.com_addr = 10'd0;
    step();
    checkOutput("retainA_data0", 32'(ifa.com_data), 32'h00000011);
    ifa.oe_c = 1'b0;

    // Wait-state instance: write 0x42@2 with a request ignored during WAIT.
    ifb.we = 1'b1; ifb.be = 1'b1; ifb.data_addr = 10'd2; ifb.data_write = 8'h42;
    ifb.d_req = 1'b1;
    pushB(8'h00);
    step();
    checkOutput("busyB_w1", 32'(ifb.d_busy), 32'd1);
    checkOutput("ackB_w1",  32'(ifb.d_ack),  32'd0);
    ifb.data_write = 8'hEE;
    step();
    checkOutput("busyB_w2", 32'(ifb.d_busy), 32'd1);
    ifb.d_req = 1'b0;
    step();
    checkOutput("busyB_w3", 32'(ifb.d_busy), 32'd1);
    checkOutput("ackB_w3",  32'(ifb.d_ack),  32'd0);
    step();
    checkOutput("ackB_latency", 32'(ifb.d_ack),  32'd1);
    checkOutput("busyB_ack",    32'(ifb.d_busy), 32'd0);
    step();
    checkOutput("ackB_pulse", 32'(ifb.d_ack), 32'd0);

    // Read held through WAIT and ACK: accepted again straight out of ACK.
    ifb.we = 1'b0; ifb.data_addr = 10'd2; ifb.d_req = 1'b1;
    pushB(8'h42);
    pushB(8'h42);
    step();
    step();
    step();
    step();
    checkOutput("ackB_held", 32'(ifb.d_ack), 32'd1);
    step();
    checkOutput("busyB_b2b", 32'(ifb.d_busy), 32'd1);
    checkOutput("ackB_b2b",  32'(ifb.d_ack),  32'd0);
    ifb.d_req = 1'b0;
    waitAckB(5);
    step();

    // Reset during WAIT of a write must drop it.
    ifb.we = 1'b1; ifb.data_addr = 10'd2; ifb.data_write = 8'hFF; ifb.d_req = 1'b1;
    step();
    ifb.d_req = 1'b0;
    step();
    checkOutput("busyB_preRst", 32'(ifb.d_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstB_mid_busy",      32'(ifb.d_busy),    32'd0);
    checkOutput("rstB_mid_data_read", 32'(ifb.data_read), 32'd0);
    #2 rst = 1'b0;
    step();
    step();
    ifb.we = 1'b0; ifb.data_addr = 10'd2; ifb.d_req = 1'b1;
    pushB(8'h42);
    step();
    ifb.d_req = 1'b0;
    waitAckB(6);
    step();
    step();

    checkOutput("sbA_empty", 32'(sb_a.size()), 32'd0);
    checkOutput("sbB_empty", 32'(sb_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
